// File: rtl/amo_unit.sv
// ---------------------------------------------------------------------------
// amo_unit
//   Serves the A-extension operations that the MEM stage hands off: LR, SC and
//   the AMO read-modify-write family. It talks to the data memory through a
//   simple request/ack port. It also holds the single LR/SC reservation, which
//   is cleared by a snoop invalidate or by a timeout.
//
// Handshakes:
//   amo_req/amo_ack : 4-phase. The requester holds amo_req until amo_ack rises.
//                     amo_ack (and amo_rd) then stay up until amo_req drops.
//   mem_req/mem_ack : mem_req is held (with stable we/addr/be/wdata) until the
//                     one-cycle mem_ack pulse. A mem_ack seen in IDLE/DONE is
//                     ignored.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   amo_req/op/w         request level, funct5, 1 = .W / 0 = .D
//   amo_addr/amo_rs2     aligned effective address, rs2 operand
//   amo_ack/amo_rd       completion level and rd result
//   mem_req/we/addr/be   data-memory request (dword address, byte enables)
//   mem_wdata/rdata/ack  write data, read data, completion pulse
//   inv_vld/inv_addr     snoop / foreign-store invalidate of a dword
//   dbg_state            current FSM state (IDLE=0, RD=1, WR=2, DONE=3)
//   dbg_rsv_vld          reservation valid flag
// ---------------------------------------------------------------------------
module amo_unit #(
  parameter int XLEN        = 64,
  parameter int RSV_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            amo_req,
  input  logic [4:0]      amo_op,
  input  logic            amo_w,
  input  logic [XLEN-1:0] amo_addr,
  input  logic [XLEN-1:0] amo_rs2,
  output logic            amo_ack,
  output logic [XLEN-1:0] amo_rd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [7:0]      mem_be,
  output logic [63:0]     mem_wdata,
  input  logic [63:0]     mem_rdata,
  input  logic            mem_ack,
  input  logic            inv_vld,
  input  logic [XLEN-1:0] inv_addr,
  output logic [1:0]      dbg_state,
  output logic            dbg_rsv_vld
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SWAP = 5'b00001;
  localparam logic [4:0] OP_LR   = 5'b00010;
  localparam logic [4:0] OP_SC   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01100;
  localparam logic [4:0] OP_MIN  = 5'b10000;
  localparam logic [4:0] OP_MAX  = 5'b10100;
  localparam logic [4:0] OP_MINU = 5'b11000;
  localparam logic [4:0] OP_MAXU = 5'b11100;

  localparam int CW = (RSV_TIMEOUT > 0) ? $clog2(RSV_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2, S_DONE = 2'd3} state_t;

  state_t          r_state, w_next;
  logic [4:0]      r_op;
  logic            r_w;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_rs2;
  logic [XLEN-1:0] r_old;
  logic [XLEN-1:0] r_new;
  logic [XLEN-1:0] r_rd;
  logic            r_rsv_vld;
  logic [XLEN-4:0] r_rsv_addr;
  logic [CW-1:0]   r_rsv_cnt;

  logic            w_is_lr, w_is_sc, w_in_sc;
  logic            w_inv_hit, w_sc_hit, w_rsv_set, w_rsv_clr;
  logic [31:0]     w_word;
  logic [XLEN-1:0] w_old, w_new;
  logic            w_lt_s, w_lt_u;
  logic            w_unused;

  assign w_is_lr = (r_op == OP_LR);
  assign w_is_sc = (r_op == OP_SC);
  assign w_in_sc = (amo_op == OP_SC);

  // An invalidate landing in the same cycle as an SC kills the hit.
  assign w_inv_hit = inv_vld && (inv_addr[XLEN-1:3] == r_rsv_addr);
  assign w_sc_hit  = r_rsv_vld && (r_rsv_addr == amo_addr[XLEN-1:3]) && !w_inv_hit;

  // Old value as seen by the core: selected word sign-extended for .W.
  assign w_word = r_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
  assign w_old  = r_w ? {{32{w_word[31]}}, w_word} : mem_rdata;

  // For .W only the low 32 bits of w_new are ever written.
  always_comb begin
    w_lt_s = r_w ? ($signed(w_old[31:0]) < $signed(r_rs2[31:0])) : ($signed(w_old) < $signed(r_rs2));
    w_lt_u = r_w ? (w_old[31:0] < r_rs2[31:0]) : (w_old < r_rs2);
    case (r_op)
      OP_ADD:  w_new = w_old + r_rs2;
      OP_SWAP: w_new = r_rs2;
      OP_XOR:  w_new = w_old ^ r_rs2;
      OP_OR:   w_new = w_old | r_rs2;
      OP_AND:  w_new = w_old & r_rs2;
      OP_MIN:  w_new = w_lt_s ? w_old : r_rs2;
      OP_MAX:  w_new = w_lt_s ? r_rs2 : w_old;
      OP_MINU: w_new = w_lt_u ? w_old : r_rs2;
      OP_MAXU: w_new = w_lt_u ? r_rs2 : w_old;
      default: w_new = r_rs2;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (amo_req) begin
        if (w_in_sc) w_next = w_sc_hit ? S_WR : S_DONE;
        else         w_next = S_RD;
      end
      S_RD:   if (mem_ack) w_next = w_is_lr ? S_DONE : S_WR;
      S_WR:   if (mem_ack) w_next = S_DONE;
      S_DONE: if (!amo_req) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    amo_ack   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 8'h00;
    mem_wdata = 64'd0;
    case (r_state)
      S_RD: begin
        mem_req = 1'b1;
        mem_be  = 8'hFF;
      end
      S_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (r_w) begin
          mem_be    = r_addr[2] ? 8'hF0 : 8'h0F;
          mem_wdata = {r_new[31:0], r_new[31:0]};
        end else begin
          mem_be    = 8'hFF;
          mem_wdata = r_new;
        end
      end
      S_DONE: amo_ack = 1'b1;
      default: ;
    endcase
  end

  assign amo_rd      = r_rd;
  assign mem_addr    = {r_addr[XLEN-1:3], 3'b000};
  assign dbg_state   = r_state;
  assign dbg_rsv_vld = r_rsv_vld;

  // Operand capture and result datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op   <= '0;
      r_w    <= 1'b0;
      r_addr <= '0;
      r_rs2  <= '0;
      r_old  <= '0;
      r_new  <= '0;
      r_rd   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (amo_req) begin
          r_op   <= amo_op;
          r_w    <= amo_w;
          r_addr <= amo_addr;
          r_rs2  <= amo_rs2;
          r_new  <= amo_rs2;  // SC store data
          if (w_in_sc && !w_sc_hit) r_rd <= XLEN'(1);
        end
        S_RD: if (mem_ack) begin
          r_old <= w_old;
          r_new <= w_new;
          if (w_is_lr) r_rd <= w_old;
        end
        S_WR: if (mem_ack) r_rd <= w_is_sc ? '0 : r_old;
        default: ;
      endcase
    end
  end

  // Reservation: an LR set beats any clear in the same cycle. Every SC
  // consumes the reservation at acceptance, whether it hits or not.
  assign w_rsv_set = (r_state == S_RD) && mem_ack && w_is_lr;
  assign w_rsv_clr = w_inv_hit || ((r_state == S_IDLE) && amo_req && w_in_sc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsv_vld  <= 1'b0;
      r_rsv_addr <= '0;
      r_rsv_cnt  <= '0;
    end else if (w_rsv_set) begin
      r_rsv_vld  <= 1'b1;
      r_rsv_addr <= r_addr[XLEN-1:3];
      r_rsv_cnt  <= CW'(RSV_TIMEOUT);
    end else if (w_rsv_clr) begin
      r_rsv_vld <= 1'b0;
      r_rsv_cnt <= '0;
    end else if (r_rsv_vld && (RSV_TIMEOUT != 0)) begin
      r_rsv_cnt <= r_rsv_cnt - CW'(1);
      if (r_rsv_cnt == CW'(1)) r_rsv_vld <= 1'b0;
    end
  end

  assign w_unused = ^{inv_addr[2:0], r_addr[1:0]};

endmodule
